// File: rtl/ltc_adc_pkg.sv
// Shared constants, types and helpers for the LTC232x SDO capture path.
package ltc_adc_pkg;

   localparam int LTC_MAX_LANES    = 4;
   localparam int LTC_MAX_AVG_LOG2 = 4;

   typedef logic [7:0] frame_count_t;

   function automatic int edges_per_frame(input int bits, input int lanes);
      return bits / lanes;
   endfunction

endpackage

// File: rtl/ltc_channel_deser.sv
// One ADC channel: multi-lane shift register, optional MSB flip, frame
// accumulator and the held output word.
module ltc_channel_deser #(
   parameter int BITS           = 16,
   parameter int LANES          = 1,
   parameter int OUT_BITS       = 13,
   parameter int AVG_LOG2       = 0,
   parameter int TWOS_TO_OFFSET = 0
) (
   input  logic                adc_clkout,
   input  logic                reset_150mhz,
   input  logic [LANES-1:0]    sdo_i,
   input  logic                frameDone_i,
   input  logic                publish_i,
   output logic [OUT_BITS-1:0] word_o
);

   localparam int ACC_W = BITS + AVG_LOG2;

   logic [BITS-1:0]     shift_q, shift_d;
   logic [BITS-1:0]     laneBits;
   logic [BITS-1:0]     sample;
   logic [ACC_W-1:0]    acc_q, acc_d;
   logic [OUT_BITS-1:0] word_q, word_d;

   // Lane 0 lands in the more significant position of each edge's bit group;
   // the average is taken straight from the top of the widened accumulator.
   always_comb begin
      laneBits = '0;
      for (int j = 0; j < LANES; j++) begin
         laneBits[LANES-1-j] = sdo_i[j];
      end
      shift_d = (shift_q << LANES) | laneBits;
      sample  = shift_d;
      if (TWOS_TO_OFFSET != 0) begin
         sample[BITS-1] = ~shift_d[BITS-1];
      end
      acc_d  = acc_q + ACC_W'(sample);
      word_d = acc_d[ACC_W-1 -: OUT_BITS];
   end

   always_ff @(posedge adc_clkout or posedge reset_150mhz) begin
      if (reset_150mhz) begin
         shift_q <= '0;
         acc_q   <= '0;
         word_q  <= '0;
      end else begin
         shift_q <= shift_d;
         if (publish_i) begin
            acc_q  <= '0;
            word_q <= word_d;
         end else if (frameDone_i) begin
            acc_q <= acc_d;
         end
      end
   end

   assign word_o = word_q;

endmodule

// File: rtl/ltc_sdo_deserializer.sv
// Multi-channel LTC232x SDO deserializer: shared frame/average counters plus
// one ltc_channel_deser per channel, publishing held words and a frame toggle.
module ltc_sdo_deserializer
   import ltc_adc_pkg::*;
#(
   parameter int N_CH           = 8,
   parameter int BITS           = 16,
   parameter int LANES          = 1,
   parameter int OUT_BITS       = 13,
   parameter int AVG_LOG2       = 0,
   parameter int TWOS_TO_OFFSET = 0
) (
   input  logic                     adc_clkout,
   input  logic                     reset_150mhz,
   input  logic [N_CH*LANES-1:0]    adc_sdo,
   output logic [N_CH*OUT_BITS-1:0] ain_data,
   output logic                     frame_toggle,
   output frame_count_t             frame_count
);

   localparam int EDGES = edges_per_frame(BITS, LANES);
   localparam int CNT_W = (EDGES > 1) ? $clog2(EDGES) : 1;
   localparam int AVG_N = 1 << AVG_LOG2;
   localparam int AVG_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

   if ((LANES != 1) && (LANES != 2) && (LANES != LTC_MAX_LANES)) begin : gBadLanes
      $fatal(1, "ltc_sdo_deserializer: LANES must be 1, 2 or 4");
   end
   if ((BITS % LANES) != 0) begin : gBadBits
      $fatal(1, "ltc_sdo_deserializer: BITS must be a multiple of LANES");
   end
   if (OUT_BITS > BITS) begin : gBadOut
      $fatal(1, "ltc_sdo_deserializer: OUT_BITS must not exceed BITS");
   end
   if ((AVG_LOG2 < 0) || (AVG_LOG2 > LTC_MAX_AVG_LOG2)) begin : gBadAvg
      $fatal(1, "ltc_sdo_deserializer: AVG_LOG2 must be 0..4");
   end

   logic [CNT_W-1:0] edgeCnt_q, edgeCnt_d;
   logic [AVG_W-1:0] avgCnt_q, avgCnt_d;
   logic             frameToggle_q, frameToggle_d;
   frame_count_t     frameCount_q, frameCount_d;
   logic             frameDone;
   logic             publish;

   // Framing is purely edge-count based; only reset can realign it.
   always_comb begin
      frameDone     = (edgeCnt_q == CNT_W'(EDGES - 1));
      publish       = frameDone && (avgCnt_q == AVG_W'(AVG_N - 1));
      edgeCnt_d     = frameDone ? '0 : edgeCnt_q + 1'b1;
      avgCnt_d      = avgCnt_q;
      frameToggle_d = frameToggle_q;
      frameCount_d  = frameCount_q;
      if (publish) begin
         avgCnt_d      = '0;
         frameToggle_d = ~frameToggle_q;
         frameCount_d  = frameCount_q + 8'd1;
      end else if (frameDone) begin
         avgCnt_d = avgCnt_q + 1'b1;
      end
   end

   always_ff @(posedge adc_clkout or posedge reset_150mhz) begin
      if (reset_150mhz) begin
         edgeCnt_q     <= '0;
         avgCnt_q      <= '0;
         frameToggle_q <= 1'b0;
         frameCount_q  <= '0;
      end else begin
         edgeCnt_q     <= edgeCnt_d;
         avgCnt_q      <= avgCnt_d;
         frameToggle_q <= frameToggle_d;
         frameCount_q  <= frameCount_d;
      end
   end

   for (genvar c = 0; c < N_CH; c++) begin : gCh
      ltc_channel_deser #(
         .BITS           (BITS),
         .LANES          (LANES),
         .OUT_BITS       (OUT_BITS),
         .AVG_LOG2       (AVG_LOG2),
         .TWOS_TO_OFFSET (TWOS_TO_OFFSET)
      ) uCh (
         .adc_clkout   (adc_clkout),
         .reset_150mhz (reset_150mhz),
         .sdo_i        (adc_sdo[c*LANES +: LANES]),
         .frameDone_i  (frameDone),
         .publish_i    (publish),
         .word_o       (ain_data[c*OUT_BITS +: OUT_BITS])
      );
   end

   assign frame_toggle = frameToggle_q;
   assign frame_count  = frameCount_q;

endmodule

// File: tb/tb_ltc_sdo_deserializer.sv
// Scoreboard bench: a default single-lane instance and a 2-lane, averaging,
// offset-converting instance, each checked against a sum/divide reference model.
module tb_ltc_sdo_deserializer;
   import ltc_adc_pkg::*;

   localparam int A_NCH = 8, A_BITS = 16, A_LANES = 1, A_OUT = 13, A_AVG = 0, A_TWOS = 0;
   localparam int B_NCH = 4, B_BITS = 16, B_LANES = 2, B_OUT = 16, B_AVG = 2, B_TWOS = 1;
   localparam int A_EDGES = A_BITS / A_LANES;
   localparam int B_EDGES = B_BITS / B_LANES;

   logic clkA = 1'b0, clkB = 1'b0, reset = 1'b1;
   logic [A_NCH*A_LANES-1:0] sdoA = '0;
   logic [B_NCH*B_LANES-1:0] sdoB = '0;
   logic [A_NCH*A_OUT-1:0]   ainA;
   logic [B_NCH*B_OUT-1:0]   ainB;
   logic                     dutToggleA, dutToggleB;
   frame_count_t             dutCountA, dutCountB;

   ltc_sdo_deserializer #(
      .N_CH(A_NCH), .BITS(A_BITS), .LANES(A_LANES), .OUT_BITS(A_OUT),
      .AVG_LOG2(A_AVG), .TWOS_TO_OFFSET(A_TWOS)
   ) dutA (
      .adc_clkout(clkA), .reset_150mhz(reset), .adc_sdo(sdoA),
      .ain_data(ainA), .frame_toggle(dutToggleA), .frame_count(dutCountA)
   );

   ltc_sdo_deserializer #(
      .N_CH(B_NCH), .BITS(B_BITS), .LANES(B_LANES), .OUT_BITS(B_OUT),
      .AVG_LOG2(B_AVG), .TWOS_TO_OFFSET(B_TWOS)
   ) dutB (
      .adc_clkout(clkB), .reset_150mhz(reset), .adc_sdo(sdoB),
      .ain_data(ainB), .frame_toggle(dutToggleB), .frame_count(dutCountB)
   );

   typedef struct {
      logic [127:0] data;
      logic         tog;
      logic [7:0]   cnt;
   } exp_t;

   exp_t         qA[$], qB[$];
   int           checks = 0, fails = 0;
   longint       accA[A_NCH], accB[B_NCH];
   int           avgA, avgB;
   logic         modelToggleA, modelToggleB;
   logic [7:0]   modelCountA, modelCountB;
   logic [127:0] lastA, lastB;

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic modelReset();
      for (int c = 0; c < A_NCH; c++) accA[c] = 0;
      for (int c = 0; c < B_NCH; c++) accB[c] = 0;
      avgA = 0; avgB = 0;
      modelToggleA = 1'b0; modelToggleB = 1'b0;
      modelCountA = 8'd0; modelCountB = 8'd0;
      lastA = '0; lastB = '0;
   endtask

   // Reference: sum (offset-converted) samples, divide by frame count, keep top OUT bits.
   task automatic modelFrameA(input int unsigned w[A_NCH]);
      exp_t e;
      for (int c = 0; c < A_NCH; c++)
         accA[c] += longint'(w[c] ^ ((A_TWOS != 0) ? (32'h1 << (A_BITS-1)) : 32'h0));
      avgA++;
      if (avgA == (1 << A_AVG)) begin
         e.data = '0;
         for (int c = 0; c < A_NCH; c++)
            e.data[c*A_OUT +: A_OUT] = A_OUT'((accA[c] / (64'sd1 << A_AVG)) / (64'sd1 << (A_BITS - A_OUT)));
         modelToggleA = ~modelToggleA;
         modelCountA  = modelCountA + 8'd1;
         e.tog = modelToggleA;
         e.cnt = modelCountA;
         lastA = e.data;
         qA.push_back(e);
         for (int c = 0; c < A_NCH; c++) accA[c] = 0;
         avgA = 0;
      end
   endtask

   task automatic modelFrameB(input int unsigned w[B_NCH]);
      exp_t e;
      for (int c = 0; c < B_NCH; c++)
         accB[c] += longint'(w[c] ^ ((B_TWOS != 0) ? (32'h1 << (B_BITS-1)) : 32'h0));
      avgB++;
      if (avgB == (1 << B_AVG)) begin
         e.data = '0;
         for (int c = 0; c < B_NCH; c++)
            e.data[c*B_OUT +: B_OUT] = B_OUT'((accB[c] / (64'sd1 << B_AVG)) / (64'sd1 << (B_BITS - B_OUT)));
         modelToggleB = ~modelToggleB;
         modelCountB  = modelCountB + 8'd1;
         e.tog = modelToggleB;
         e.cnt = modelCountB;
         lastB = e.data;
         qB.push_back(e);
         for (int c = 0; c < B_NCH; c++) accB[c] = 0;
         avgB = 0;
      end
   endtask

   // Serialises one frame MSB-first, lane 0 carrying the higher bit of each edge.
   task automatic applyStimulusA(input int unsigned w[A_NCH], input int nEdges, input bit doModel);
      logic [127:0] prevData = lastA;
      logic         prevTog  = modelToggleA;
      if (doModel) modelFrameA(w);
      for (int e = 0; e < nEdges; e++) begin
         for (int c = 0; c < A_NCH; c++)
            for (int j = 0; j < A_LANES; j++)
               sdoA[c*A_LANES+j] = w[c][A_BITS-1-(e*A_LANES+j)];
         #5 clkA = 1'b1;
         #1;
         if (doModel && e == A_EDGES/2) begin
            checkOutput("midFrameA.data", 128'(ainA), prevData);
            checkOutput("midFrameA.toggle", 128'(dutToggleA), 128'(prevTog));
         end
         #4 clkA = 1'b0;
      end
   endtask

   task automatic applyStimulusB(input int unsigned w[B_NCH], input int nEdges, input bit doModel);
      logic [127:0] prevData = lastB;
      logic         prevTog  = modelToggleB;
      if (doModel) modelFrameB(w);
      for (int e = 0; e < nEdges; e++) begin
         for (int c = 0; c < B_NCH; c++)
            for (int j = 0; j < B_LANES; j++)
               sdoB[c*B_LANES+j] = w[c][B_BITS-1-(e*B_LANES+j)];
         #5 clkB = 1'b1;
         #1;
         if (doModel && e == B_EDGES/2) begin
            checkOutput("midFrameB.data", 128'(ainB), prevData);
            checkOutput("midFrameB.toggle", 128'(dutToggleB), 128'(prevTog));
         end
         #4 clkB = 1'b0;
      end
   endtask

   initial begin : monA
      exp_t e;
      forever begin
         @(dutToggleA);
         #1;
         if (!reset) begin
            if (qA.size() == 0) begin
               checks++; fails++;
               $display("[TB] FAIL monA.unexpected: toggle went to %0d, no publish expected", dutToggleA);
            end else begin
               e = qA.pop_front();
               checkOutput("monA.data", 128'(ainA), e.data);
               checkOutput("monA.toggle", 128'(dutToggleA), 128'(e.tog));
               checkOutput("monA.count", 128'(dutCountA), 128'(e.cnt));
            end
         end
      end
   end

   initial begin : monB
      exp_t e;
      forever begin
         @(dutToggleB);
         #1;
         if (!reset) begin
            if (qB.size() == 0) begin
               checks++; fails++;
               $display("[TB] FAIL monB.unexpected: toggle went to %0d, no publish expected", dutToggleB);
            end else begin
               e = qB.pop_front();
               checkOutput("monB.data", 128'(ainB), e.data);
               checkOutput("monB.toggle", 128'(dutToggleB), 128'(e.tog));
               checkOutput("monB.count", 128'(dutCountB), 128'(e.cnt));
            end
         end
      end
   end

   initial begin : main
      int unsigned wA[A_NCH];
      int unsigned wB[B_NCH];
      int unsigned avgVals[4];
      modelReset();
      #20;
      checkOutput("reset.ainA", 128'(ainA), 128'd0);
      checkOutput("reset.toggleA", 128'(dutToggleA), 128'd0);
      checkOutput("reset.countA", 128'(dutCountA), 128'd0);
      checkOutput("reset.ainB", 128'(ainB), 128'd0);
      checkOutput("reset.toggleB", 128'(dutToggleB), 128'd0);
      checkOutput("reset.countB", 128'(dutCountB), 128'd0);
      reset = 1'b0;
      #10;

      wA = '{default: 0};
      wA[0] = 32'hABCD;
      applyStimulusA(wA, A_EDGES, 1'b1);
      #20;
      checkOutput("dirA.ch0", 128'(ainA[A_OUT-1:0]), 128'h1579);
      checkOutput("dirA.count", 128'(dutCountA), 128'd1);

      avgVals = '{100, 200, 300, 403};
      for (int f = 0; f < 4; f++) begin
         wB[0] = avgVals[f];
         wB[1] = (f % 2 == 1) ? 32'hFFFF : 32'h0;
         wB[2] = $urandom_range(0, 65535);
         wB[3] = 32'h8001;
         applyStimulusB(wB, B_EDGES, 1'b1);
      end
      #20;
      checkOutput("dirB.ch0", 128'(ainB[15:0]), 128'h80FA);
      checkOutput("dirB.ch1", 128'(ainB[31:16]), 128'h7FFF);
      checkOutput("dirB.ch3", 128'(ainB[63:48]), 128'h0001);
      checkOutput("dirB.count", 128'(dutCountB), 128'd1);

      for (int i = 0; i < 20; i++) begin
         for (int c = 0; c < A_NCH; c++) wA[c] = $urandom_range(0, 65535);
         for (int c = 0; c < B_NCH; c++) wB[c] = $urandom_range(0, 65535);
         applyStimulusA(wA, A_EDGES, 1'b1);
         applyStimulusB(wB, B_EDGES, 1'b1);
         if ($urandom_range(0, 3) == 0) begin
            #1000;
            checkOutput("gapA.data", 128'(ainA), lastA);
            checkOutput("gapB.data", 128'(ainB), lastB);
         end
      end
      #1000;
      checkOutput("gapA.hold", 128'(ainA), lastA);
      checkOutput("gapB.hold", 128'(ainB), lastB);

      // Abandon partial frames mid-burst, then realign with reset.
      for (int c = 0; c < A_NCH; c++) wA[c] = $urandom_range(0, 65535);
      for (int c = 0; c < B_NCH; c++) wB[c] = $urandom_range(0, 65535);
      applyStimulusA(wA, 7, 1'b0);
      applyStimulusB(wB, 3, 1'b0);
      checkOutput("sbA.preReset", 128'(qA.size()), 128'd0);
      checkOutput("sbB.preReset", 128'(qB.size()), 128'd0);
      qA.delete();
      qB.delete();
      reset = 1'b1;
      #2;
      checkOutput("midReset.ainA", 128'(ainA), 128'd0);
      checkOutput("midReset.toggleA", 128'(dutToggleA), 128'd0);
      checkOutput("midReset.countA", 128'(dutCountA), 128'd0);
      checkOutput("midReset.ainB", 128'(ainB), 128'd0);
      checkOutput("midReset.countB", 128'(dutCountB), 128'd0);
      modelReset();
      #50 reset = 1'b0;
      #10;
      wA = '{default: 0};
      wA[0] = 32'h1234;
      applyStimulusA(wA, A_EDGES, 1'b1);
      #20;
      checkOutput("postReset.ch0", 128'(ainA[A_OUT-1:0]), 128'h0246);
      checkOutput("postReset.count", 128'(dutCountA), 128'd1);
      for (int f = 0; f < 4; f++) begin
         for (int c = 0; c < B_NCH; c++) wB[c] = $urandom_range(0, 65535);
         applyStimulusB(wB, B_EDGES, 1'b1);
      end

      for (int f = 0; f < 255; f++) begin
         for (int c = 0; c < A_NCH; c++) wA[c] = $urandom_range(0, 65535);
         applyStimulusA(wA, A_EDGES, 1'b1);
      end
      #20;
      checkOutput("wrap.count", 128'(dutCountA), 128'd0);
      checkOutput("wrap.toggle", 128'(dutToggleA), 128'd0);
      #1000;
      checkOutput("wrap.hold", 128'(ainA), lastA);

      checkOutput("sbA.drained", 128'(qA.size()), 128'd0);
      checkOutput("sbB.drained", 128'(qB.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
